// File: rtl/chroni_text_fetch.sv
// chroni_text_fetch: text-mode scanline fetcher for the chroni video path.
// Each line_start renders one scanline into the line buffer. Character codes
// are fetched into a local buffer on the first scanline of a text row. After
// that, one font byte per column is read and written out as an 8-pixel
// pattern plus colour indices.
// Optional feature: define CHRONI_TEXT_ATTR_EN to fetch a per-character
// attribute byte (fg = attr[3:0], bg = attr[7:4]) stored COLS bytes after
// each row's codes. The row stride then doubles to 2*COLS.
module chroni_text_fetch #(
  parameter int COLS        = 80,
  parameter int FONT_H_LOG2 = 3,
  parameter int ADDR_W      = 16,
  parameter int LB_ADDR_W   = 11
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 line_start,
  input  logic                 lb_half,
  input  logic [ADDR_W-1:0]    text_base,
  input  logic [ADDR_W-1:0]    font_base,
  input  logic [7:0]           fg_default,
  input  logic [7:0]           bg_default,
  output logic [ADDR_W-1:0]    addr_out,
  output logic                 rd_req,
  input  logic                 rd_ack,
  input  logic [7:0]           data_in,
  output logic                 dma_req,
  output logic                 lb_wr_en,
  output logic [LB_ADDR_W-1:0] lb_wr_addr,
  output logic [7:0]           lb_wr_pattern,
  output logic [7:0]           lb_wr_fg,
  output logic [7:0]           lb_wr_bg,
  input  logic                 lb_wr_busy,
  output logic                 line_done,
  output logic                 overrun
);

  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SCAN_W = (FONT_H_LOG2 > 0) ? FONT_H_LOG2 : 1;
`ifdef CHRONI_TEXT_ATTR_EN
  localparam int ROW_STRIDE = 2 * COLS;
`else
  localparam int ROW_STRIDE = COLS;
`endif
  localparam logic [COL_W-1:0]     LAST_COL  = COL_W'(COLS - 1);
  localparam logic [SCAN_W-1:0]    LAST_SCAN = SCAN_W'((1 << FONT_H_LOG2) - 1);
  localparam logic [ADDR_W-1:0]    COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0]    STRIDE_A  = ADDR_W'(ROW_STRIDE);
  localparam logic [LB_ADDR_W-1:0] HALF_PIX  = LB_ADDR_W'(COLS * 8);

`ifdef CHRONI_TEXT_ATTR_EN
  typedef enum logic [2:0] {
    IDLE, CHR_REQ, CHR_WAIT, ATTR_REQ, ATTR_WAIT, FNT_REQ, FNT_WAIT, WR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, CHR_REQ, CHR_WAIT, FNT_REQ, FNT_WAIT, WR
  } state_t;
`endif

  state_t               state;
  logic [COL_W-1:0]     col;
  logic [SCAN_W-1:0]    scan;
  logic [ADDR_W-1:0]    row_addr;
  logic [ADDR_W-1:0]    font_base_q;
  logic [LB_ADDR_W-1:0] base_pix;
  logic [7:0]           pattern;
  logic [7:0]           charbuf [COLS];

  logic [ADDR_W-1:0]    chr_addr;
  logic [ADDR_W-1:0]    font_addr;
  logic [LB_ADDR_W-1:0] wr_addr;
  logic                 chr_we;

  // Address arithmetic wraps at the port widths; all 8 code bits select a glyph.
  always_comb begin
    chr_addr  = row_addr + ADDR_W'(col);
    font_addr = font_base_q + (ADDR_W'(charbuf[col]) << FONT_H_LOG2) + ADDR_W'(scan);
    wr_addr   = base_pix + (LB_ADDR_W'(col) << 3);
    chr_we    = (state == CHR_WAIT) && rd_ack && !frame_start && !line_start;
  end

  // Character code buffer, filled on the first scanline of each text row.
  always_ff @(posedge sys_clk) begin
    if (chr_we) charbuf[col] <= data_in;
  end

`ifdef CHRONI_TEXT_ATTR_EN
  logic [7:0] attrbuf [COLS];
  logic       attr_we;
  logic       unused_defaults;

  // Attribute capture strobe; default colours are superseded by attributes.
  always_comb begin
    attr_we         = (state == ATTR_WAIT) && rd_ack && !frame_start && !line_start;
    unused_defaults = ^{fg_default, bg_default};
  end

  // Attribute buffer, filled alongside the character codes.
  always_ff @(posedge sys_clk) begin
    if (attr_we) attrbuf[col] <= data_in;
  end
`endif

  // Fetch sequencer: frame_start outranks line_start, which outranks the FSM.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      col           <= '0;
      scan          <= '0;
      row_addr      <= '0;
      font_base_q   <= '0;
      base_pix      <= '0;
      pattern       <= '0;
      addr_out      <= '0;
      rd_req        <= 1'b0;
      dma_req       <= 1'b0;
      lb_wr_en      <= 1'b0;
      lb_wr_addr    <= '0;
      lb_wr_pattern <= '0;
      lb_wr_fg      <= '0;
      lb_wr_bg      <= '0;
      line_done     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      lb_wr_en  <= 1'b0;
      line_done <= 1'b0;
      overrun   <= 1'b0;
      if (frame_start) begin
        rd_req   <= 1'b0;
        dma_req  <= 1'b0;
        row_addr <= text_base;
        scan     <= '0;
        col      <= '0;
        state    <= IDLE;
      end else if (line_start) begin
        // A line still in flight is dropped; scan and row_addr stay put.
        overrun     <= (state != IDLE);
        rd_req      <= 1'b0;
        col         <= '0;
        base_pix    <= lb_half ? HALF_PIX : '0;
        font_base_q <= font_base;
        dma_req     <= 1'b1;
        state       <= (scan == '0) ? CHR_REQ : FNT_REQ;
      end else begin
        case (state)
          IDLE: ;
          CHR_REQ: begin
            addr_out <= chr_addr;
            rd_req   <= 1'b1;
            state    <= CHR_WAIT;
          end
          CHR_WAIT: begin
            if (rd_ack) begin
              rd_req <= 1'b0;
`ifdef CHRONI_TEXT_ATTR_EN
              state  <= ATTR_REQ;
`else
              if (col == LAST_COL) begin
                col   <= '0;
                state <= FNT_REQ;
              end else begin
                col   <= col + 1'b1;
                state <= CHR_REQ;
              end
`endif
            end
          end
`ifdef CHRONI_TEXT_ATTR_EN
          ATTR_REQ: begin
            addr_out <= chr_addr + COLS_A;
            rd_req   <= 1'b1;
            state    <= ATTR_WAIT;
          end
          ATTR_WAIT: begin
            if (rd_ack) begin
              rd_req <= 1'b0;
              if (col == LAST_COL) begin
                col   <= '0;
                state <= FNT_REQ;
              end else begin
                col   <= col + 1'b1;
                state <= CHR_REQ;
              end
            end
          end
`endif
          FNT_REQ: begin
            addr_out <= font_addr;
            rd_req   <= 1'b1;
            state    <= FNT_WAIT;
          end
          FNT_WAIT: begin
            if (rd_ack) begin
              rd_req  <= 1'b0;
              pattern <= data_in;
              state   <= WR;
            end
          end
          WR: begin
            if (!lb_wr_busy) begin
              lb_wr_en      <= 1'b1;
              lb_wr_addr    <= wr_addr;
              lb_wr_pattern <= pattern;
`ifdef CHRONI_TEXT_ATTR_EN
              lb_wr_fg      <= {4'b0, attrbuf[col][3:0]};
              lb_wr_bg      <= {4'b0, attrbuf[col][7:4]};
`else
              lb_wr_fg      <= fg_default;
              lb_wr_bg      <= bg_default;
`endif
              if (col == LAST_COL) begin
                dma_req   <= 1'b0;
                line_done <= 1'b1;
                col       <= '0;
                state     <= IDLE;
                if (scan == LAST_SCAN) begin
                  scan     <= '0;
                  row_addr <= row_addr + STRIDE_A;
                end else begin
                  scan <= scan + 1'b1;
                end
              end else begin
                col   <= col + 1'b1;
                state <= FNT_REQ;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chroni_text_fetch.sv
// Directed bench for chroni_text_fetch with COLS=4 and an 8-line font.
// A behavioural memory answers reads after a programmable number of cycles.
// A monitor logs read addresses, line buffer writes and pulse counts, and the
// directed sequence compares those logs against hand-derived expectations.
module tb_chroni_text_fetch;

  localparam int COLS = 4;
`ifdef CHRONI_TEXT_ATTR_EN
  localparam logic [15:0] STRIDE = 16'd8;
  localparam logic [7:0]  EXP_FG = 8'h0A;
  localparam logic [7:0]  EXP_BG = 8'h05;
`else
  localparam logic [15:0] STRIDE = 16'd4;
  localparam logic [7:0]  EXP_FG = 8'h0F;
  localparam logic [7:0]  EXP_BG = 8'h01;
`endif

  logic        sys_clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        lb_half = 1'b0;
  logic [15:0] text_base = 16'h1E00;
  logic [15:0] font_base = 16'h0000;
  logic [7:0]  fg_default = 8'h0F;
  logic [7:0]  bg_default = 8'h01;
  logic [15:0] addr_out;
  logic        rd_req;
  logic        rd_ack = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        dma_req;
  logic        lb_wr_en;
  logic [10:0] lb_wr_addr;
  logic [7:0]  lb_wr_pattern;
  logic [7:0]  lb_wr_fg;
  logic [7:0]  lb_wr_bg;
  logic        lb_wr_busy = 1'b0;
  logic        line_done;
  logic        overrun;

  chroni_text_fetch #(.COLS(COLS), .FONT_H_LOG2(3), .ADDR_W(16), .LB_ADDR_W(11)) dut (
    .sys_clk(sys_clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .lb_half(lb_half), .text_base(text_base), .font_base(font_base),
    .fg_default(fg_default), .bg_default(bg_default), .addr_out(addr_out),
    .rd_req(rd_req), .rd_ack(rd_ack), .data_in(data_in), .dma_req(dma_req),
    .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_pattern(lb_wr_pattern),
    .lb_wr_fg(lb_wr_fg), .lb_wr_bg(lb_wr_bg), .lb_wr_busy(lb_wr_busy),
    .line_done(line_done), .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  pat;
    logic [7:0]  fg;
    logic [7:0]  bg;
    int          cyc;
  } wr_t;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q [$];
  wr_t         wr_q [$];
  int cyc = 0, done_cnt = 0, ov_cnt = 0, ls_cyc = 0, done_cyc = 0;
  int ack_delay = 0, wait_cnt = 0;
  int errors = 0, checks = 0;

  // Monitor plus memory responder, sampled 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge sys_clk);
      cyc++;
      #1;
      if (lb_wr_en) wr_q.push_back('{lb_wr_addr, lb_wr_pattern, lb_wr_fg, lb_wr_bg, cyc});
      if (line_done) begin done_cnt++; done_cyc = cyc; end
      if (overrun) ov_cnt++;
      if (line_start) ls_cyc = cyc;
      if (rd_ack) rd_ack = 1'b0;
      else if (rd_req) begin
        if (wait_cnt >= ack_delay) begin
          rd_ack   = 1'b1;
          data_in  = mem[addr_out];
          rd_q.push_back(addr_out);
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_line(input logic half);
    @(negedge sys_clk);
    lb_half    = half;
    line_start = 1'b1;
    @(negedge sys_clk);
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev);
    int n = 0;
    while (done_cnt == prev && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, "_done"}, done_cnt, prev + 1);
  endtask

  // Compare logged reads and writes for one rendered line, then clear the logs.
  task automatic check_line(input string tag, input logic with_chr, input logic [15:0] row_base,
                            input logic [7:0] code0, input int scan, input int pix0);
    logic [15:0] exp [$];
    logic [15:0] fa [COLS];
    logic [7:0]  cc;
    for (int c = 0; c < COLS; c++) begin
      cc    = code0 + 8'(c);
      fa[c] = ({8'h00, cc} << 3) + 16'(scan);
    end
    if (with_chr) begin
      for (int c = 0; c < COLS; c++) begin
        exp.push_back(row_base + 16'(c));
`ifdef CHRONI_TEXT_ATTR_EN
        exp.push_back(row_base + 16'(COLS + c));
`endif
      end
    end
    for (int c = 0; c < COLS; c++) exp.push_back(fa[c]);
    chk({tag, "_nrd"}, rd_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rd_q.size(); i++)
      chk($sformatf("%s_rd%0d", tag, i), rd_q[i], exp[i]);
    chk({tag, "_nwr"}, wr_q.size(), COLS);
    for (int i = 0; i < wr_q.size() && i < COLS; i++) begin
      chk($sformatf("%s_wa%0d", tag, i), wr_q[i].addr, pix0 + 8 * i);
      chk($sformatf("%s_wp%0d", tag, i), wr_q[i].pat, fa[i][7:0] ^ 8'h3C);
      chk($sformatf("%s_fg%0d", tag, i), wr_q[i].fg, EXP_FG);
      chk($sformatf("%s_bg%0d", tag, i), wr_q[i].bg, EXP_BG);
    end
    rd_q.delete();
    wr_q.delete();
  endtask

  initial begin
    int prev, n, first;
    for (int i = 0; i < 65536; i++) mem[i] = (i < 'h1000) ? (8'(i) ^ 8'h3C) : 8'h00;
    for (int c = 0; c < COLS; c++) begin
      mem[16'h1E00 + c] = 8'h41 + 8'(c);
`ifdef CHRONI_TEXT_ATTR_EN
      mem[16'h1E04 + c] = 8'h5A;
      mem[16'h1E08 + c] = 8'h45 + 8'(c);
      mem[16'h1E0C + c] = 8'h5A;
`else
      mem[16'h1E04 + c] = 8'h45 + 8'(c);
`endif
    end

    // Reset state
    #1 reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_addr_out", addr_out, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_dma_req", dma_req, 0);
    chk("rst_lb_wr_en", lb_wr_en, 0);
    chk("rst_lb_wr_addr", lb_wr_addr, 0);
    chk("rst_lb_wr_pattern", lb_wr_pattern, 0);
    chk("rst_lb_wr_fg", lb_wr_fg, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;

    @(negedge sys_clk) frame_start = 1'b1;
    @(negedge sys_clk) frame_start = 1'b0;

    // Line 1: scan 0, character fetch then font fetch
    prev = done_cnt;
    pulse_line(1'b0);
    wait_done("l1", prev);
    check_line("l1", 1'b1, 16'h1E00, 8'h41, 0, 0);
    chk("l1_cnt", done_cnt, 1);
    chk("l1_ov", ov_cnt, 0);
    chk("l1_dma", dma_req, 0);

    // Line 2: scan 1, upper half, 3 cycles per column
    prev = done_cnt;
    pulse_line(1'b1);
    wait_done("l2", prev);
    first = (wr_q.size() > 0) ? wr_q[0].cyc : -1;
    chk("l2_lat_wr", first - ls_cyc, 3);
    chk("l2_lat_done", done_cyc - ls_cyc, 12);
    check_line("l2", 1'b0, 16'h1E00, 8'h41, 1, 32);

    // Line 3: line buffer busy stalls the first write by 5 cycles
    prev = done_cnt;
    @(negedge sys_clk) lb_wr_busy = 1'b1;
    pulse_line(1'b0);
    repeat (7) @(negedge sys_clk);
    lb_wr_busy = 1'b0;
    wait_done("l3", prev);
    first = (wr_q.size() > 0) ? wr_q[0].cyc : -1;
    chk("l3_lat_wr", first - ls_cyc, 8);
    chk("l3_lat_done", done_cyc - ls_cyc, 17);
    check_line("l3", 1'b0, 16'h1E00, 8'h41, 2, 0);

    // Lines 4..8: remaining scanlines of row 0
    for (int s = 3; s < 8; s++) begin
      prev = done_cnt;
      pulse_line(1'b0);
      wait_done($sformatf("s%0d", s), prev);
      check_line($sformatf("s%0d", s), 1'b0, 16'h1E00, 8'h41, s, 0);
    end

    // Line 9: next text row fetched one stride further on
    prev = done_cnt;
    pulse_line(1'b0);
    wait_done("l9", prev);
    check_line("l9", 1'b1, 16'h1E00 + STRIDE, 8'h45, 0, 0);

    // Overrun: line_start while column 2 waits for its font byte
    ack_delay = 3;
    pulse_line(1'b0);
    n = 0;
    while (!(wr_q.size() == 2 && rd_req) && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk("ab_reach", (wr_q.size() == 2 && rd_req), 1);
    prev = done_cnt;
    pulse_line(1'b0);
    rd_q.delete();
    wr_q.delete();
    ack_delay = 0;
    wait_done("ab", prev);
    chk("ab_overrun", ov_cnt, 1);
    check_line("ab", 1'b0, 16'h1E00 + STRIDE, 8'h45, 1, 0);

    // frame_start mid-line drops the request and restarts from text_base
    ack_delay = 3;
    prev = done_cnt;
    pulse_line(1'b0);
    n = 0;
    while (!rd_req && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    chk("fs_busy_rd_req", rd_req, 1);
    chk("fs_busy_dma", dma_req, 1);
    @(negedge sys_clk) frame_start = 1'b1;
    @(posedge sys_clk);
    #2;
    chk("fs_rd_req", rd_req, 0);
    chk("fs_dma_req", dma_req, 0);
    @(negedge sys_clk) frame_start = 1'b0;
    repeat (6) @(negedge sys_clk);
    chk("fs_no_done", done_cnt, prev);
    chk("fs_no_overrun", ov_cnt, 1);
    ack_delay = 0;
    rd_q.delete();
    wr_q.delete();
    pulse_line(1'b0);
    wait_done("fs", prev);
    check_line("fs", 1'b1, 16'h1E00, 8'h41, 0, 0);
    chk("fs_overrun_after", ov_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
